// File: rtl/hex_pkg.sv
// Shared constants for the hex rate counter slice.
// Speed codes, nibble width and the step period lookup.
package hex_pkg;

  localparam logic [1:0] SPD_FAST = 2'b00;
  localparam logic [1:0] SPD_1HZ  = 2'b01;
  localparam logic [1:0] SPD_HALF = 2'b10;
  localparam logic [1:0] SPD_QTR  = 2'b11;

  localparam int NIBBLE_W = 4;

  typedef logic [NIBBLE_W-1:0] nibble_t;

  // Clock cycles between steps for a speed code.
  function automatic int unsigned period_cycles(
    input logic [1:0]  spd,
    input int unsigned hz
  );
    int unsigned p;
    p = 1;
    unique case (spd)
      SPD_FAST: p = 1;
      SPD_1HZ:  p = hz;
      SPD_HALF: p = 2 * hz;
      SPD_QTR:  p = 4 * hz;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/hex_rate_counter_divider.sv
// Step-rate divider for the hex rate counter.
// Owns the down-counting divider and the last-cycle speed copy.
module rate_divider
  import hex_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int          DIV_W  = $clog2(4 * CLK_HZ)
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] speed,
  input  logic       clear,
  output logic       step_en
);

  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_speed;

  logic [DIV_W-1:0] w_reload;
  logic             w_spd_chg;
  logic             w_zero;

  assign w_reload  = DIV_W'(period_cycles(speed, CLK_HZ) - 1);
  assign w_spd_chg = (speed != r_speed);
  assign w_zero    = (r_div == '0);

  // A step is due only when nothing of higher priority claims the edge.
  assign step_en = ~reset & ~clear & ~w_spd_chg
                 & enable & w_zero;

  // Divider and speed copy; load or speed change restarts a full period.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_div   <= w_reload;
      r_speed <= speed;
    end else begin
      r_speed <= speed;
      if (clear || w_spd_chg) begin
        r_div <= w_reload;
      end else if (enable) begin
        if (w_zero) begin
          r_div <= w_reload;
        end else begin
          r_div <= r_div - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hex_rate_counter.sv
// Rate-divided 4-bit up/down counter feeding a hex digit.
// Emits tick/wrap pulses so a second digit can be chained.
module hex_rate_counter
  import hex_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int          DIV_W  = $clog2(4 * CLK_HZ)
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          speed,
  input  logic                up,
  input  logic                load,
  input  logic [NIBBLE_W-1:0] load_val,
  output logic [NIBBLE_W-1:0] value,
  output logic                tick,
  output logic                wrap
);

  nibble_t r_value;
  logic    r_tick;
  logic    r_wrap;

  logic    w_step;
  nibble_t w_next;
  logic    w_edge;

  rate_divider #(
    .CLK_HZ (CLK_HZ),
    .DIV_W  (DIV_W)
  ) u_div (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .enable   (enable),
    .speed    (speed),
    .clear    (load),
    .step_en  (w_step)
  );

  assign w_next = up ? r_value + 1'b1
                     : r_value - 1'b1;
  assign w_edge = up ? (r_value == '1)
                     : (r_value == '0);

  // Count register with single-cycle tick/wrap pulses.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_value <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (load) begin
      r_value <= load_val;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (w_step) begin
      r_value <= w_next;
      r_tick  <= 1'b1;
      r_wrap  <= w_edge;
    end else begin
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end
  end

  assign value = r_value;
  assign tick  = r_tick;
  assign wrap  = r_wrap;

  a_wrap_tick: assert property (
    @(posedge CLOCK_50) r_wrap |-> r_tick
  );

  a_load_no_step: assert property (
    @(posedge CLOCK_50) load |-> !w_step
  );

endmodule

// File: tb/tb_hex_rate_counter.sv
// Self-checking bench for hex_rate_counter.
// Directed literal checks plus randomized traffic against a model.
module tb_hex_rate_counter;

  localparam int unsigned HZ = 4;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       enable;
  logic [1:0] speed;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] value;
  logic       tick;
  logic       wrap;

  int n_cmp = 0;
  int n_mis = 0;

  int m_val  = 0;
  int m_rem  = 0;
  int m_lspd = 0;
  bit m_tick = 0;
  bit m_wrap = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  hex_rate_counter #(.CLK_HZ(HZ)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .enable   (enable),
    .speed    (speed),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .value    (value),
    .tick     (tick),
    .wrap     (wrap)
  );

  function automatic int per(input int s);
    if (s == 0) return 1;
    return int'(HZ) * (1 << (s - 1));
  endfunction

  task automatic model_edge();
    int old;
    old = m_lspd;
    if (reset) begin
      m_val  = 0;
      m_tick = 0;
      m_wrap = 0;
      m_rem  = per(int'(speed)) - 1;
      m_lspd = int'(speed);
    end else begin
      m_lspd = int'(speed);
      m_tick = 0;
      m_wrap = 0;
      if (load) begin
        m_val = int'(load_val);
        m_rem = per(int'(speed)) - 1;
      end else if (int'(speed) != old) begin
        m_rem = per(int'(speed)) - 1;
      end else if (enable && m_rem == 0) begin
        m_tick = 1;
        m_wrap = up ? (m_val == 15) : (m_val == 0);
        m_val  = up ? (m_val + 1) % 16 : (m_val + 15) % 16;
        m_rem  = per(int'(speed)) - 1;
      end else if (enable) begin
        m_rem = m_rem - 1;
      end
    end
  endtask

  task automatic compare();
    n_cmp++;
    if (value !== 4'(m_val) || tick !== m_tick
        || wrap !== m_wrap) begin
      n_mis++;
      $display("FAIL model t=%0t got v=%h t=%b w=%b want v=%h t=%b w=%b",
               $time, value, tick, wrap, 4'(m_val), m_tick, m_wrap);
    end
  endtask

  task automatic lit(input string nm, input int v,
                     input bit t, input bit w);
    n_cmp++;
    if (value !== 4'(v) || tick !== t || wrap !== w) begin
      n_mis++;
      $display("FAIL %s got v=%h t=%b w=%b want v=%h t=%b w=%b",
               nm, value, tick, wrap, 4'(v), t, w);
    end
    n_cmp++;
    if (m_val != v || m_tick != t || m_wrap != w) begin
      n_mis++;
      $display("FAIL %s_model got v=%0d t=%b w=%b want v=%0d t=%b w=%b",
               nm, m_val, m_tick, m_wrap, v, t, w);
    end
  endtask

  task automatic cyc(input bit r, input bit ld, input logic [3:0] lv,
                     input bit en, input logic [1:0] sp, input bit u);
    reset    = r;
    load     = ld;
    load_val = lv;
    enable   = en;
    speed    = sp;
    up       = u;
    @(posedge CLOCK_50);
    model_edge();
    @(negedge CLOCK_50);
    compare();
  endtask

  initial begin
    logic [1:0] sp;
    bit         u;
    reset    = 1'b1;
    load     = 1'b0;
    load_val = 4'h0;
    enable   = 1'b0;
    speed    = 2'b00;
    up       = 1'b1;

    // reset with random side inputs
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1'($urandom), 4'($urandom), 1'($urandom),
          2'($urandom), 1'($urandom));
      lit("reset", 0, 0, 0);
    end
    cyc(1, 0, 4'h0, 0, 2'b00, 1);
    lit("reset_fast", 0, 0, 0);

    // every-cycle counting up
    for (int i = 1; i <= 20; i++) begin
      cyc(0, 0, 4'h0, 1, 2'b00, 1);
      lit("fast_up", i % 16, 1, i == 16);
    end

    // 1 Hz: change edge reloads, then a step every 4 cycles
    for (int c = 1; c <= 13; c++) begin
      cyc(0, 0, 4'h0, 1, 2'b01, 1);
      lit("spd_1hz", 4 + (c - 1) / 4, (c % 4 == 1) && c > 1, 0);
    end

    // quarter rate: one step 16 cycles after the change
    for (int c = 1; c <= 17; c++) begin
      cyc(0, 0, 4'h0, 1, 2'b11, 1);
      lit("spd_qtr", 7 + int'(c == 17), c == 17, 0);
    end

    // change speed mid-period: full new period from the change
    for (int c = 1; c <= 2; c++) begin
      cyc(0, 0, 4'h0, 1, 2'b01, 1);
      lit("mid_pre", 8, 0, 0);
    end
    for (int c = 1; c <= 9; c++) begin
      cyc(0, 0, 4'h0, 1, 2'b10, 1);
      lit("mid_chg", 8 + int'(c == 9), c == 9, 0);
    end

    // load 3 then count down through the 0->F wrap
    cyc(0, 1, 4'h3, 1, 2'b00, 0);
    lit("load3", 3, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 0, 4'h0, 1, 2'b00, 0);
      lit("down", (3 - i + 16) % 16, 1, i == 4);
    end

    // load on a due-step cycle wins, no tick
    cyc(0, 1, 4'hA, 1, 2'b00, 0);
    lit("load_due", 10, 0, 0);

    // pause mid-period at half rate, resume without reload
    cyc(0, 0, 4'h0, 1, 2'b10, 1);
    lit("hold_chg", 10, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 4'h0, 1, 2'b10, 1);
      lit("hold_run", 10, 0, 0);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 4'h0, 0, 2'b10, 1);
      lit("hold_off", 10, 0, 0);
    end
    for (int c = 1; c <= 5; c++) begin
      cyc(0, 0, 4'h0, 1, 2'b10, 1);
      lit("resume", 10 + int'(c == 5), c == 5, 0);
    end

    // reset beats load and a due step
    cyc(0, 0, 4'h0, 1, 2'b00, 1);
    lit("pre_rst", 11, 0, 0);
    cyc(1, 1, 4'h7, 1, 2'b00, 1);
    lit("rst_prio", 0, 0, 0);
    cyc(0, 0, 4'h0, 1, 2'b00, 1);
    lit("post_rst", 1, 1, 0);

    // randomized traffic against the model
    sp = 2'b01;
    u  = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(40) == 0) sp = 2'($urandom);
      if ($urandom_range(7) == 0)  u  = ~u;
      cyc($urandom_range(63) == 0, $urandom_range(15) == 0,
          4'($urandom), $urandom_range(3) != 0, sp, u);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule
